// File: rtl/imem_server_if.sv
// imem_server_if: fetch-side instruction port plus word-stream loader port of imem_server
interface imem_server_if #(parameter int DEPTH_LOG2 = 10);
   logic [31:0]         pc_i;
   logic [31:0]         inst_o;
   logic                halt_o;
   logic                ld_valid_i;
   logic [31:0]         ld_data_i;
   logic                ld_last_i;
   logic                ld_ready_o;
   logic [DEPTH_LOG2:0] ld_count_o;
   logic                fault_o;
   logic [31:0]         fault_addr_o;
   modport master (
      output pc_i, ld_valid_i, ld_data_i, ld_last_i,
      input  inst_o, halt_o, ld_ready_o, ld_count_o, fault_o, fault_addr_o
   );
   modport slave (
      input  pc_i, ld_valid_i, ld_data_i, ld_last_i,
      output inst_o, halt_o, ld_ready_o, ld_count_o, fault_o, fault_addr_o
   );
endinterface

// File: rtl/imem_server.sv
// imem_server: loadable instruction memory with same-cycle fetch read, halt and sticky illegal-fetch fault
module imem_server #(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
   input logic          clk,
   input logic          rst,
   imem_server_if.slave bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   typedef enum logic [1:0] {LOAD, RUN, FAULT} state_t;
   state_t                  state, state_nx;
   logic [31:0]             mem [DEPTH];
   logic [DEPTH_LOG2:0]     cnt;
   logic [DEPTH_LOG2-1:0]   idx;
   logic                    bad_pc, xfer, fault;
   logic [31:0]             fault_addr;
   assign idx    = bus.pc_i[DEPTH_LOG2+1:2];
   assign bad_pc = (|bus.pc_i[1:0]) | (|bus.pc_i[31:DEPTH_LOG2+2]) | ({1'b0, idx} >= cnt);
   assign xfer   = (state == LOAD) & bus.ld_valid_i;
   always_comb begin
      state_nx = state;
      if (state == LOAD && xfer && (bus.ld_last_i || cnt == (DEPTH_LOG2+1)'(DEPTH-1)))
         state_nx = RUN;
      else if (state == RUN && bad_pc)
         state_nx = FAULT;
   end
   assign bus.ld_ready_o   = state == LOAD;
   assign bus.halt_o       = (state != RUN) | bad_pc;
   assign bus.inst_o       = (state == RUN && !bad_pc) ? mem[idx] : NOP_WORD;
   assign bus.ld_count_o   = cnt;
   assign bus.fault_o      = fault;
   assign bus.fault_addr_o = fault_addr;
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= LOAD;
         cnt        <= '0;
         fault      <= 1'b0;
         fault_addr <= '0;
      end else begin
         state <= state_nx;
         if (xfer) cnt <= cnt + 1'b1;
         if (state == RUN && bad_pc) begin
            fault      <= 1'b1;
            fault_addr <= bus.pc_i;
         end
      end
   end
   // reset wins over a coincident loader word, so the write is gated too
   always_ff @(posedge clk)
      if (xfer && !rst) mem[cnt[DEPTH_LOG2-1:0]] <= bus.ld_data_i;
endmodule

// File: tb/tb_imem_server.sv
// tb_imem_server: directed scenario tests for imem_server
module tb_imem_server;
   localparam int DL = 10;
   localparam int DEPTH = 1 << DL;
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic clk = 0;
   logic rst = 1;
   int total = 0;
   int bad = 0;
   imem_server_if #(.DEPTH_LOG2(DL)) bus();
   imem_server #(.DEPTH_LOG2(DL), .NOP_WORD(NOP)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1;
      bus.ld_valid_i = 0;
      tick();
      rst = 0;
   endtask

   task automatic load_words(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         bus.ld_valid_i = 1;
         bus.ld_data_i = base + 32'(i);
         bus.ld_last_i = (i == n - 1);
         tick();
      end
      bus.ld_valid_i = 0;
      bus.ld_last_i = 0;
   endtask

   task automatic test_reset();
      bus.pc_i = 32'hFFFF_FFFC;
      bus.ld_valid_i = 0;
      bus.ld_data_i = 0;
      bus.ld_last_i = 0;
      do_reset();
      total++;
      if (bus.ld_count_o !== 0 || bus.fault_o !== 0 || bus.fault_addr_o !== 0) begin
         bad++;
         $display("FAIL reset count=%0d fault=%b addr=%h exp 0/0/0", bus.ld_count_o, bus.fault_o, bus.fault_addr_o);
      end
      total++;
      if (bus.ld_ready_o !== 1 || bus.halt_o !== 1 || bus.inst_o !== NOP) begin
         bad++;
         $display("FAIL reset_outs ready=%b halt=%b inst=%h exp 1/1/%h", bus.ld_ready_o, bus.halt_o, bus.inst_o, NOP);
      end
   endtask

   task automatic test_load_basic();
      logic [31:0] prog [3];
      prog[0] = 32'h0050_0093;
      prog[1] = 32'h0010_8113;
      prog[2] = 32'h0000_006F;
      do_reset();
      bus.pc_i = 32'hFFFF_FFFC;
      for (int i = 0; i < 3; i++) begin
         bus.ld_valid_i = 1;
         bus.ld_data_i = prog[i];
         bus.ld_last_i = (i == 2);
         total++;
         if (bus.ld_ready_o !== 1 || bus.halt_o !== 1 || bus.inst_o !== NOP) begin
            bad++;
            $display("FAIL load_cycle%0d ready=%b halt=%b inst=%h exp 1/1/%h", i, bus.ld_ready_o, bus.halt_o, bus.inst_o, NOP);
         end
         tick();
      end
      bus.ld_valid_i = 0;
      bus.ld_last_i = 0;
      bus.pc_i = 4;
      #1;
      total++;
      if (bus.ld_count_o !== 3 || bus.ld_ready_o !== 0 || bus.halt_o !== 0 || bus.fault_o !== 0) begin
         bad++;
         $display("FAIL load_done count=%0d ready=%b halt=%b fault=%b exp 3/0/0/0", bus.ld_count_o, bus.ld_ready_o, bus.halt_o, bus.fault_o);
      end
      total++;
      if (bus.inst_o !== 32'h0010_8113) begin
         bad++;
         $display("FAIL fetch_pc4 got=%h exp=%h", bus.inst_o, 32'h0010_8113);
      end
      bus.pc_i = 8;
      #1;
      total++;
      if (bus.inst_o !== 32'h0000_006F || bus.halt_o !== 0) begin
         bad++;
         $display("FAIL fetch_pc8 got=%h halt=%b exp=%h/0", bus.inst_o, bus.halt_o, 32'h0000_006F);
      end
      // loader is ignored once running
      bus.pc_i = 0;
      bus.ld_valid_i = 1;
      bus.ld_data_i = 32'hDEAD_BEEF;
      tick();
      bus.ld_valid_i = 0;
      total++;
      if (bus.ld_count_o !== 3 || bus.inst_o !== 32'h0050_0093 || bus.ld_ready_o !== 0) begin
         bad++;
         $display("FAIL run_ld_ignored count=%0d inst=%h ready=%b exp 3/00500093/0", bus.ld_count_o, bus.inst_o, bus.ld_ready_o);
      end
   endtask

   task automatic test_bad_index();
      bus.pc_i = 32'h0000_000C;
      #1;
      total++;
      if (bus.halt_o !== 1 || bus.inst_o !== NOP || bus.fault_o !== 0) begin
         bad++;
         $display("FAIL bad_index_comb halt=%b inst=%h fault=%b exp 1/%h/0", bus.halt_o, bus.inst_o, bus.fault_o, NOP);
      end
      tick();
      bus.pc_i = 0;
      #1;
      total++;
      if (bus.fault_o !== 1 || bus.fault_addr_o !== 32'hC || bus.halt_o !== 1 || bus.inst_o !== NOP || bus.ld_ready_o !== 0) begin
         bad++;
         $display("FAIL bad_index_fault fault=%b addr=%h halt=%b inst=%h ready=%b exp 1/0000000c/1/%h/0", bus.fault_o, bus.fault_addr_o, bus.halt_o, bus.inst_o, bus.ld_ready_o, NOP);
      end
      bus.pc_i = 4;
      tick();
      tick();
      total++;
      if (bus.fault_o !== 1 || bus.fault_addr_o !== 32'hC || bus.halt_o !== 1) begin
         bad++;
         $display("FAIL fault_sticky fault=%b addr=%h halt=%b exp 1/0000000c/1", bus.fault_o, bus.fault_addr_o, bus.halt_o);
      end
   endtask

   task automatic test_reset_in_fault();
      rst = 1;
      tick();
      rst = 0;
      total++;
      if (bus.fault_o !== 0 || bus.fault_addr_o !== 0 || bus.ld_count_o !== 0 || bus.ld_ready_o !== 1 || bus.halt_o !== 1) begin
         bad++;
         $display("FAIL rst_in_fault fault=%b addr=%h count=%0d ready=%b halt=%b exp 0/0/0/1/1", bus.fault_o, bus.fault_addr_o, bus.ld_count_o, bus.ld_ready_o, bus.halt_o);
      end
   endtask

   task automatic test_gaps();
      do_reset();
      bus.ld_valid_i = 1;
      bus.ld_data_i = 32'h1111_1111;
      bus.ld_last_i = 0;
      tick();
      bus.ld_valid_i = 0;
      bus.ld_data_i = 32'h9999_9999;
      bus.ld_last_i = 1;
      tick();
      total++;
      if (bus.ld_count_o !== 1 || bus.halt_o !== 1 || bus.ld_ready_o !== 1) begin
         bad++;
         $display("FAIL gap_idle count=%0d halt=%b ready=%b exp 1/1/1", bus.ld_count_o, bus.halt_o, bus.ld_ready_o);
      end
      bus.ld_valid_i = 1;
      bus.ld_data_i = 32'h2222_2222;
      tick();
      bus.ld_valid_i = 0;
      bus.ld_last_i = 0;
      bus.pc_i = 4;
      #1;
      total++;
      if (bus.ld_count_o !== 2 || bus.halt_o !== 0 || bus.inst_o !== 32'h2222_2222) begin
         bad++;
         $display("FAIL gap_done count=%0d halt=%b inst=%h exp 2/0/22222222", bus.ld_count_o, bus.halt_o, bus.inst_o);
      end
   endtask

   task automatic test_addr_faults();
      logic [31:0] addrs [2];
      addrs[0] = 32'h0000_0002;
      addrs[1] = 32'h0000_1000;
      for (int k = 0; k < 2; k++) begin
         do_reset();
         load_words(4, 32'h0000_0100);
         bus.pc_i = addrs[k];
         #1;
         total++;
         if (bus.halt_o !== 1 || bus.inst_o !== NOP) begin
            bad++;
            $display("FAIL addr_comb%0d halt=%b inst=%h exp 1/%h", k, bus.halt_o, bus.inst_o, NOP);
         end
         tick();
         total++;
         if (bus.fault_o !== 1 || bus.fault_addr_o !== addrs[k]) begin
            bad++;
            $display("FAIL addr_fault%0d fault=%b addr=%h exp 1/%h", k, bus.fault_o, bus.fault_addr_o, addrs[k]);
         end
      end
   endtask

   task automatic test_full_load();
      do_reset();
      bus.pc_i = 0;
      for (int i = 0; i < DEPTH; i++) begin
         bus.ld_valid_i = 1;
         bus.ld_data_i = 32'hA500_0000 ^ 32'(i * 7);
         bus.ld_last_i = 0;
         tick();
         if (i == DEPTH - 2) begin
            total++;
            if (bus.halt_o !== 1 || bus.ld_ready_o !== 1) begin
               bad++;
               $display("FAIL full_pre halt=%b ready=%b exp 1/1", bus.halt_o, bus.ld_ready_o);
            end
         end
      end
      bus.pc_i = 32'(4 * (DEPTH - 1));
      #1;
      total++;
      if (bus.ld_count_o !== (DL+1)'(DEPTH) || bus.ld_ready_o !== 0 || bus.halt_o !== 0) begin
         bad++;
         $display("FAIL full_done count=%0d ready=%b halt=%b exp %0d/0/0", bus.ld_count_o, bus.ld_ready_o, bus.halt_o, DEPTH);
      end
      total++;
      if (bus.inst_o !== (32'hA500_0000 ^ 32'((DEPTH - 1) * 7))) begin
         bad++;
         $display("FAIL full_last got=%h exp=%h", bus.inst_o, 32'hA500_0000 ^ 32'((DEPTH - 1) * 7));
      end
      bus.ld_valid_i = 1;
      tick();
      bus.ld_valid_i = 0;
      total++;
      if (bus.ld_count_o !== (DL+1)'(DEPTH) || bus.fault_o !== 0) begin
         bad++;
         $display("FAIL full_saturate count=%0d fault=%b exp %0d/0", bus.ld_count_o, bus.fault_o, DEPTH);
      end
   endtask

   task automatic test_reset_mid_load();
      do_reset();
      bus.ld_valid_i = 1;
      bus.ld_data_i = 32'h3333_3333;
      bus.ld_last_i = 0;
      tick();
      bus.ld_data_i = 32'h4444_4444;
      rst = 1;
      tick();
      rst = 0;
      bus.ld_valid_i = 0;
      total++;
      if (bus.ld_count_o !== 0 || bus.ld_ready_o !== 1 || bus.fault_o !== 0 || bus.halt_o !== 1) begin
         bad++;
         $display("FAIL rst_mid_load count=%0d ready=%b fault=%b halt=%b exp 0/1/0/1", bus.ld_count_o, bus.ld_ready_o, bus.fault_o, bus.halt_o);
      end
      bus.ld_valid_i = 1;
      bus.ld_data_i = 32'h5555_5555;
      bus.ld_last_i = 1;
      tick();
      bus.ld_valid_i = 0;
      bus.ld_last_i = 0;
      bus.pc_i = 0;
      #1;
      total++;
      if (bus.ld_count_o !== 1 || bus.halt_o !== 0 || bus.inst_o !== 32'h5555_5555) begin
         bad++;
         $display("FAIL one_word count=%0d halt=%b inst=%h exp 1/0/55555555", bus.ld_count_o, bus.halt_o, bus.inst_o);
      end
      bus.pc_i = 4;
      #1;
      total++;
      if (bus.halt_o !== 1 || bus.inst_o !== NOP) begin
         bad++;
         $display("FAIL stale_word halt=%b inst=%h exp 1/%h", bus.halt_o, bus.inst_o, NOP);
      end
   endtask

   initial begin
      test_reset();
      test_load_basic();
      test_bad_index();
      test_reset_in_fault();
      test_gaps();
      test_addr_faults();
      test_full_load();
      test_reset_mid_load();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
